// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared constants and entry type for the instruction fetch unit
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
`ifdef IF_PREDECODE_EN
        logic               is_ctrl;
`endif
    } fetch_entry_t;

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry FIFO with synchronous reset and flush
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && (r_count != CNT_W'(FIFO_DEPTH));
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Flush has priority over any push/pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Credit-based instruction fetch with 2-entry decode buffer.
//               Define IF_PREDECODE_EN to add the o_IsCtrl predecode output.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_IReq,
    output logic [31:0] o_IAddr,
    input  logic        i_IGnt,
    input  logic        i_IRvalid,
    input  logic [31:0] i_IRdata,
    output logic        o_Valid,
    output logic [31:0] o_Instr,
    output logic [31:0] o_PC,
    input  logic        i_Ready,
    input  logic        i_Redirect,
    input  logic [31:0] i_Target
`ifdef IF_PREDECODE_EN
    ,
    output logic        o_IsCtrl
`endif
);

    localparam int ENTRY_W = $bits(fetch_entry_t);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_out_pc;
    logic               r_outstanding;
    logic               w_fifo_valid;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_inflight;
    logic               w_pop;
    logic               w_push;
    logic               w_grant;
    fetch_entry_t       w_din;
    fetch_entry_t       w_head;
    logic [ENTRY_W-1:0] w_dout;
    logic               w_unused_tgt;

    assign w_unused_tgt = ^i_Target[1:0];

    assign o_Valid = w_fifo_valid && !i_rst;
    assign w_pop   = o_Valid && i_Ready;

    // Slots already claimed (buffered + in flight) after this cycle's pop
    assign w_inflight = {1'b0, w_count} + {{CNT_W{1'b0}}, r_outstanding}
                      - {{CNT_W{1'b0}}, w_pop};
    assign o_IReq   = !i_rst && !i_Redirect && (w_inflight < (CNT_W+1)'(FIFO_DEPTH));
    assign w_grant  = o_IReq && i_IGnt;
    assign w_push   = i_IRvalid && r_outstanding && !i_Redirect && !i_rst;
    assign o_IAddr  = r_fetch_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_out_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
        end else if (i_Redirect) begin
            r_fetch_pc    <= {i_Target[31:2], 2'b00};
            r_outstanding <= 1'b0;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_out_pc   <= r_fetch_pc;
            end
            r_outstanding <= w_grant || (r_outstanding && !i_IRvalid);
        end
    end

    always_comb begin
        w_din       = '0;
        w_din.pc    = r_out_pc;
        w_din.instr = i_IRdata;
`ifdef IF_PREDECODE_EN
        w_din.is_ctrl = is_ctrl_op(i_IRdata[6:0]);
`endif
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (i_Redirect),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .valid (w_fifo_valid),
        .count (w_count)
    );

    assign w_head  = fetch_entry_t'(w_dout);
    assign o_Instr = w_head.instr;
    assign o_PC    = w_head.pc;
`ifdef IF_PREDECODE_EN
    assign o_IsCtrl = o_Valid && w_head.is_ctrl;
`endif

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetched instruction after reset.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 o_IReq  output  1  instruction-memory request valid.
REQ-005 o_IAddr  output  32  request address, word aligned.
REQ-006 i_IGnt  input  1  memory accepts the request this cycle.
REQ-007 i_IRvalid  input  1  read data valid, exactly one cycle after a grant.
REQ-008 i_IRdata  input  32  instruction word.
REQ-009 o_Valid  output  1  instruction available to decode.
REQ-010 o_Instr  output  32  instruction word to decode; o_Instr[6:0] drives the decoder opcode input.
REQ-011 o_PC  output  32  address of o_Instr.
REQ-012 i_Ready  input  1  decode consumes the head entry when o_Valid is high.
REQ-013 i_Redirect  input  1  flush and restart fetch, from branch/jump resolution.
REQ-014 i_Target  input  32  restart address; bits [1:0] are ignored and treated as zero.

Function
REQ-015 The block SHALL hold a fetch PC register; each grant (o_IReq & i_IGnt) SHALL advance it by 4, with modulo-2^32 wrap.
REQ-016 o_IAddr SHALL equal the fetch PC.
REQ-017 The block SHALL buffer {PC, instr} pairs in a 2-entry FIFO; o_Valid SHALL be high when the FIFO is non-empty, with o_Instr/o_PC taken from the head.
REQ-018 A pop SHALL occur when o_Valid & i_Ready; a push SHALL occur when i_IRvalid is high and is not discarded.
REQ-019 The block SHALL track outstanding grants (0 or 1); o_IReq SHALL be high only when fifo_count + outstanding - pop_this_cycle < 2, with i_Redirect low and i_rst low.
REQ-020 With i_IGnt tied high and i_Ready tied high, throughput SHALL be 1 instruction per cycle; the first o_Valid SHALL occur 2 cycles after the first request.
REQ-021 Simultaneous push and pop on a full FIFO SHALL NOT occur, because the credit rule prevents it; a simultaneous push and pop at count 1 SHALL leave count at 1.
REQ-022 While i_Redirect is high, o_IReq SHALL be forced low combinationally.
REQ-023 In a redirect cycle, the block SHALL clear the FIFO, discard any i_IRvalid response in that cycle, and clear the outstanding count.
REQ-024 On the next edge after a redirect cycle, the fetch PC SHALL load {i_Target[31:2], 2'b00}.
REQ-025 While i_Redirect is high, o_Valid SHALL remain as stored, but decode SHALL ignore it; the pop in that cycle has no effect beyond the flush.
REQ-026 An i_IRvalid with no outstanding grant SHALL be ignored.
REQ-027 o_IReq SHALL NOT depend on i_IGnt, so there is no combinational loop on the memory side.

Reset
REQ-028 While i_rst is high: o_IReq=0, o_Valid=0, fetch PC=RESET_PC, FIFO empty, outstanding=0, and responses are discarded.
REQ-029 The first request SHALL occur in the first cycle after i_rst deasserts, with o_IAddr=RESET_PC.
REQ-030 Asserting reset mid-stream SHALL discard all buffered and in-flight instructions.

Configuration
REQ-031 Macro IF_PREDECODE_EN compiles in an extra output o_IsCtrl (1 bit).
REQ-032 With IF_PREDECODE_EN defined, o_IsCtrl SHALL be 1 when the head opcode is 7'b110_0011, 7'b110_1111 or 7'b110_0111; it SHALL be stored in the FIFO alongside the instruction and be 0 when o_Valid is 0.
REQ-033 Without IF_PREDECODE_EN, the port and its storage SHALL be absent; all other behaviour is identical.

Structure
REQ-034 A shared package SHALL hold the opcode constants (OP_BRANCH, OP_JAL, OP_JALR), the instruction width 32 and the FIFO depth 2.
REQ-035 The FIFO SHALL be the sub-module fetch_fifo (2 entries, parameterized data width, synchronous reset, flush input).
REQ-036 The PC, credit and discard logic SHALL reside in instr_fetch.

Verification
REQ-037 Reset release with i_IGnt=1 and i_Ready=1 -> o_IAddr sequence 0x0, 0x4, 0x8; first o_Valid 2 cycles later with o_PC=0x0, then one instruction per cycle.
REQ-038 i_Ready=0 for 5 cycles -> FIFO holds exactly 2 entries, o_IReq low, o_PC stable at 0x0; on i_Ready=1, entries 0x0 and 0x4 appear in order with no loss or duplication.
REQ-039 Redirect to 0x103 in the same cycle as i_IRvalid -> that response is dropped, o_Valid=0 next cycle, next o_IAddr=0x100, and the next o_PC seen is 0x100.
REQ-040 i_IGnt held low for 3 cycles -> o_IReq stays high, o_IAddr stays constant, fetch PC does not advance; a spurious i_IRvalid is ignored.
REQ-041 Fetch PC 0xFFFF_FFFC granted -> next o_IAddr is 0x0.
REQ-042 With IF_PREDECODE_EN, i_IRdata=32'h0000_0063 -> o_IsCtrl=1 at the head; with 32'h0000_0013 -> o_IsCtrl=0.
